alu_operand_stage: RTL and testbench

ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

---
 rtl/pipe_pkg.sv | 23 ++
 rtl/forward_unit.sv | 25 ++
 rtl/alu_operand_stage.sv | 100 ++++++++++
 tb/tb_alu_operand_stage.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared default widths and the ID/EX pipeline register layout.
package pipe_pkg;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_OPCODE_LENGTH = 4;
   localparam int DEF_REG_ADDR_W = 5;
   typedef struct packed {
      logic valid;
      logic reg_write;
      logic mem_read;
      logic mem_write;
      logic src_a_pc;
      logic src_b_imm;
      logic [DEF_OPCODE_LENGTH-1:0] op;
      logic [DEF_REG_ADDR_W-1:0] rs1;
      logic [DEF_REG_ADDR_W-1:0] rs2;
      logic [DEF_REG_ADDR_W-1:0] rd;
      logic [DEF_DATA_WIDTH-1:0] rs1_data;
      logic [DEF_DATA_WIDTH-1:0] rs2_data;
      logic [DEF_DATA_WIDTH-1:0] imm;
      logic [DEF_DATA_WIDTH-1:0] pc;
   } id_ex_t;
   localparam id_ex_t BUBBLE = '0;
endpackage

// File: rtl/forward_unit.sv
// forward_unit: picks the freshest value of one source register (EX/MEM, then MEM/WB, then regfile).
module forward_unit
   import pipe_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
   input  logic [REG_ADDR_W-1:0] rs,
   input  logic [DATA_WIDTH-1:0] reg_data,
   input  logic                  exmem_reg_write,
   input  logic [REG_ADDR_W-1:0] exmem_rd,
   input  logic [DATA_WIDTH-1:0] exmem_result,
   input  logic                  memwb_reg_write,
   input  logic [REG_ADDR_W-1:0] memwb_rd,
   input  logic [DATA_WIDTH-1:0] memwb_result,
   output logic [DATA_WIDTH-1:0] data
);
   logic hit_exmem;
   logic hit_memwb;
   always_comb begin
      hit_exmem = exmem_reg_write && exmem_rd != '0 && exmem_rd == rs;
      hit_memwb = memwb_reg_write && memwb_rd != '0 && memwb_rd == rs;
      data = hit_exmem ? exmem_result : hit_memwb ? memwb_result : reg_data;
   end
endmodule

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: ID/EX register with load-use bubble insertion and forwarded ALU operands.
module alu_operand_stage
   import pipe_pkg::*;
#(
   parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
   parameter int OPCODE_LENGTH = DEF_OPCODE_LENGTH,
   parameter int REG_ADDR_W    = DEF_REG_ADDR_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     id_valid,
   input  logic [REG_ADDR_W-1:0]    id_rs1_addr,
   input  logic [REG_ADDR_W-1:0]    id_rs2_addr,
   input  logic [REG_ADDR_W-1:0]    id_rd_addr,
   input  logic [DATA_WIDTH-1:0]    id_rs1_data,
   input  logic [DATA_WIDTH-1:0]    id_rs2_data,
   input  logic [DATA_WIDTH-1:0]    id_imm,
   input  logic [DATA_WIDTH-1:0]    id_pc,
   input  logic [OPCODE_LENGTH-1:0] id_operation,
   input  logic                     id_src_a_pc,
   input  logic                     id_src_b_imm,
   input  logic                     id_reg_write,
   input  logic                     id_mem_read,
   input  logic                     id_mem_write,
   input  logic                     stall_in,
   input  logic                     flush_in,
   input  logic                     exmem_reg_write,
   input  logic                     memwb_reg_write,
   input  logic [REG_ADDR_W-1:0]    exmem_rd,
   input  logic [REG_ADDR_W-1:0]    memwb_rd,
   input  logic [DATA_WIDTH-1:0]    exmem_result,
   input  logic [DATA_WIDTH-1:0]    memwb_result,
   output logic [DATA_WIDTH-1:0]    SrcA,
   output logic [DATA_WIDTH-1:0]    SrcB,
   output logic [OPCODE_LENGTH-1:0] Operation,
   output logic                     ex_valid,
   output logic                     ex_reg_write,
   output logic                     ex_mem_read,
   output logic                     ex_mem_write,
   output logic [REG_ADDR_W-1:0]    ex_rd,
   output logic [DATA_WIDTH-1:0]    ex_store_data,
   output logic [DATA_WIDTH-1:0]    ex_pc,
   output logic                     load_use_stall
);
   id_ex_t ex;
   id_ex_t nxt;
   logic [DATA_WIDTH-1:0] fwd_a;
   logic [DATA_WIDTH-1:0] fwd_b;
   // control bits are gated by id_valid so an empty slot never writes anything
   always_comb begin
      nxt = BUBBLE;
      nxt.valid = id_valid;
      nxt.reg_write = id_valid & id_reg_write;
      nxt.mem_read = id_valid & id_mem_read;
      nxt.mem_write = id_valid & id_mem_write;
      nxt.src_a_pc = id_src_a_pc;
      nxt.src_b_imm = id_src_b_imm;
      nxt.op = id_operation;
      nxt.rs1 = id_rs1_addr;
      nxt.rs2 = id_rs2_addr;
      nxt.rd = id_rd_addr;
      nxt.rs1_data = id_rs1_data;
      nxt.rs2_data = id_rs2_data;
      nxt.imm = id_imm;
      nxt.pc = id_pc;
   end
   always_comb begin
      load_use_stall = ex.valid && ex.mem_read && ex.rd != '0 &&
                       (ex.rd == id_rs1_addr || ex.rd == id_rs2_addr) && id_valid;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ex <= BUBBLE;
      else if (flush_in) ex <= BUBBLE;
      else if (!stall_in) ex <= load_use_stall ? BUBBLE : nxt;
   end
   forward_unit #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
      .rs(ex.rs1), .reg_data(ex.rs1_data),
      .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
      .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
      .data(fwd_a)
   );
   forward_unit #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
      .rs(ex.rs2), .reg_data(ex.rs2_data),
      .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
      .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
      .data(fwd_b)
   );
   always_comb begin
      SrcA = ex.src_a_pc ? ex.pc : fwd_a;
      SrcB = ex.src_b_imm ? ex.imm : fwd_b;
      ex_store_data = fwd_b;
      Operation = ex.op;
      ex_valid = ex.valid;
      ex_reg_write = ex.reg_write;
      ex_mem_read = ex.mem_read;
      ex_mem_write = ex.mem_write;
      ex_rd = ex.rd;
      ex_pc = ex.pc;
   end
endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: directed scoreboard bench for the ID/EX operand stage.
module tb_alu_operand_stage;
   import pipe_pkg::*;
   logic clk = 1'b0;
   logic rst_n;
   id_ex_t id;
   logic stall_in, flush_in;
   logic exmem_reg_write, memwb_reg_write;
   logic [4:0] exmem_rd, memwb_rd;
   logic [31:0] exmem_result, memwb_result;
   logic [31:0] src_a, src_b, ex_store_data, ex_pc;
   logic [3:0] operation;
   logic ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, load_use_stall;
   logic [4:0] ex_rd;
   int tests = 0;
   int fails = 0;
   typedef struct {
      logic [31:0] a, b, st, pc;
      logic [3:0] op;
      logic [4:0] rd;
      logic v, rw, mr, mw;
   } exp_t;
   exp_t q[$];

   always #5 clk = ~clk;

   alu_operand_stage dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id.valid),
      .id_rs1_addr(id.rs1), .id_rs2_addr(id.rs2), .id_rd_addr(id.rd),
      .id_rs1_data(id.rs1_data), .id_rs2_data(id.rs2_data), .id_imm(id.imm), .id_pc(id.pc),
      .id_operation(id.op), .id_src_a_pc(id.src_a_pc), .id_src_b_imm(id.src_b_imm),
      .id_reg_write(id.reg_write), .id_mem_read(id.mem_read), .id_mem_write(id.mem_write),
      .stall_in(stall_in), .flush_in(flush_in),
      .exmem_reg_write(exmem_reg_write), .memwb_reg_write(memwb_reg_write),
      .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
      .exmem_result(exmem_result), .memwb_result(memwb_result),
      .SrcA(src_a), .SrcB(src_b), .Operation(operation),
      .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .ex_mem_write(ex_mem_write), .ex_rd(ex_rd), .ex_store_data(ex_store_data),
      .ex_pc(ex_pc), .load_use_stall(load_use_stall)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [31:0] a, b, st, pc, input logic [3:0] op,
                       input logic [4:0] rd, input logic v, rw, mr, mw);
      exp_t e;
      e.a = a; e.b = b; e.st = st; e.pc = pc; e.op = op; e.rd = rd;
      e.v = v; e.rw = rw; e.mr = mr; e.mw = mw;
      q.push_back(e);
   endtask

   task automatic push_bubble();
      push(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic pop(input string tag);
      exp_t e;
      if (q.size() == 0) begin
         tests++;
         fails++;
         $error("FAIL %s_empty: observed no entry expected one", tag);
         return;
      end
      e = q.pop_front();
      chk({tag, "_srca"}, src_a, e.a);
      chk({tag, "_srcb"}, src_b, e.b);
      chk({tag, "_store"}, ex_store_data, e.st);
      chk({tag, "_pc"}, ex_pc, e.pc);
      chk({tag, "_op"}, {28'd0, operation}, {28'd0, e.op});
      chk({tag, "_rd"}, {27'd0, ex_rd}, {27'd0, e.rd});
      chk({tag, "_valid"}, {31'd0, ex_valid}, {31'd0, e.v});
      chk({tag, "_rw"}, {31'd0, ex_reg_write}, {31'd0, e.rw});
      chk({tag, "_mr"}, {31'd0, ex_mem_read}, {31'd0, e.mr});
      chk({tag, "_mw"}, {31'd0, ex_mem_write}, {31'd0, e.mw});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      id = '0;
      stall_in = 0; flush_in = 0;
      exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
      memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
      #2;
      push_bubble();
      pop("reset0");
      chk("reset0_lus", {31'd0, load_use_stall}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      // plain ADD x3 = x1 + x2
      id.valid = 1; id.rs1 = 1; id.rs2 = 2; id.rd = 3; id.rs1_data = 5; id.rs2_data = 7;
      id.op = 4'b0010; id.reg_write = 1; id.pc = 32'h40;
      push(5, 7, 7, 32'h40, 4'b0010, 3, 1, 1, 0, 0);
      step(); pop("add");
      chk("add_lus", {31'd0, load_use_stall}, 32'd0);
      // EX/MEM beats MEM/WB on the same register
      id.rd = 5; id.rs1_data = 11; id.rs2_data = 22; id.op = 0; id.pc = 32'h44;
      exmem_reg_write = 1; exmem_rd = 1; exmem_result = 100;
      memwb_reg_write = 1; memwb_rd = 1; memwb_result = 200;
      push(100, 22, 22, 32'h44, 0, 5, 1, 1, 0, 0);
      step(); pop("fwd_exmem");
      // x0 is never forwarded; MEM/WB alone supplies rs2
      exmem_rd = 0; memwb_rd = 2;
      id.rs1 = 0; id.rs1_data = 33; id.rs2_data = 44; id.pc = 32'h48;
      push(33, 200, 200, 32'h48, 0, 5, 1, 1, 0, 0);
      step(); pop("fwd_x0_memwb");
      // load x4, then a dependent instruction
      exmem_reg_write = 0; memwb_reg_write = 0;
      id.rs1 = 1; id.rs1_data = 8; id.rs2 = 0; id.rs2_data = 0; id.rd = 4;
      id.mem_read = 1; id.src_b_imm = 1; id.imm = 4; id.pc = 32'h4c;
      push(8, 4, 0, 32'h4c, 0, 4, 1, 1, 1, 0);
      step(); pop("load");
      id.mem_read = 0; id.src_b_imm = 0; id.imm = 0;
      id.rs1 = 4; id.rs1_data = 1; id.rs2 = 3; id.rs2_data = 6; id.rd = 6; id.pc = 32'h50;
      #1 chk("lu_stall_hi", {31'd0, load_use_stall}, 32'd1);
      id.valid = 0;
      #1 chk("lu_stall_idle", {31'd0, load_use_stall}, 32'd0);
      id.valid = 1;
      #1 chk("lu_stall_hi2", {31'd0, load_use_stall}, 32'd1);
      push_bubble();
      step(); pop("lu_bubble");
      chk("lu_stall_lo", {31'd0, load_use_stall}, 32'd0);
      memwb_reg_write = 1; memwb_rd = 4; memwb_result = 77;
      push(77, 6, 6, 32'h50, 0, 6, 1, 1, 0, 0);
      step(); pop("lu_replay");
      // flush wins over stall
      memwb_reg_write = 0;
      flush_in = 1; stall_in = 1;
      push_bubble();
      step(); pop("flush_stall");
      flush_in = 0; stall_in = 0;
      // immediate operand, store data still forwarded rs2
      id.rs1 = 1; id.rs1_data = 3; id.rs2 = 2; id.rs2_data = 55; id.rd = 7; id.op = 5;
      id.src_b_imm = 1; id.imm = 32'hFFFF_FFF0; id.pc = 32'h60;
      exmem_reg_write = 1; exmem_rd = 2; exmem_result = 99;
      push(3, 32'hFFFF_FFF0, 99, 32'h60, 5, 7, 1, 1, 0, 0);
      step(); pop("imm");
      stall_in = 1;
      id.rd = 9; id.op = 3; id.rs1_data = 123; id.pc = 32'h64;
      for (int i = 0; i < 3; i++) begin
         push(3, 32'hFFFF_FFF0, 99, 32'h60, 5, 7, 1, 1, 0, 0);
         step(); pop("stall_hold");
      end
      stall_in = 0; exmem_reg_write = 0;
      // invalid slot drops its controls
      id.valid = 0; id.reg_write = 1; id.mem_read = 1; id.mem_write = 1;
      id.rs1 = 0; id.rs2 = 0; id.rs1_data = 1; id.rs2_data = 2; id.rd = 0; id.op = 0;
      id.src_b_imm = 0; id.pc = 32'h70;
      push(1, 2, 2, 32'h70, 0, 0, 0, 0, 0, 0);
      step(); pop("invalid");
      // PC as source A, then async reset while stalled
      id.valid = 1; id.mem_read = 0; id.mem_write = 0;
      id.src_a_pc = 1; id.pc = 32'h1000; id.rs1 = 1; id.rs1_data = 5; id.rs2 = 2; id.rs2_data = 6;
      id.rd = 10; id.op = 7;
      push(32'h1000, 6, 6, 32'h1000, 7, 10, 1, 1, 0, 0);
      step(); pop("pc_src");
      stall_in = 1;
      @(negedge clk);
      #1 rst_n = 0;
      #1 push_bubble();
      pop("async_rst");
      chk("async_rst_lus", {31'd0, load_use_stall}, 32'd0);
      @(negedge clk);
      rst_n = 1; stall_in = 0;
      id.src_a_pc = 0; id.rs1_data = 21; id.rs2_data = 22; id.rd = 11; id.op = 1;
      push(21, 22, 22, 32'h1000, 1, 11, 1, 1, 0, 0);
      step(); pop("post_rst");
      if (q.size() != 0) begin
         tests++;
         fails++;
         $error("FAIL scoreboard_drain: observed %0d left expected 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
